sbox_rom_arbiter: RTL

Shares the single external 256×8 S-Box ROM between several AES-side requesters, for example key expansion and the round datapath. It arbitrates between pending lookups and drives the ROM's address and active-low enables. It waits a fixed access latency, then returns the byte to the owning requester. It sits between the AES core's S-Box lookup ports and the `rom_addr` / `rom_data` / `rom_ce_n` / `rom_oe_n` pins of the AES UART top level.

---
 rtl/sbox_rom_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sbox_rom_arbiter.sv
// Shares one external 256x8 S-Box ROM between NREQ requesters: arbitrates, drives the ROM pins and returns the byte.
// Define SBOX_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module sbox_rom_arbiter #(
  parameter int NREQ    = 2,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [7:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic              rom_ce_n,
  output logic              rom_oe_n
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(ROM_LAT - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      rom_addr_q, rom_addr_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            busy_q, busy_d;

  // Widened copies so requester indices are always 2 bits regardless of NREQ.
  logic [3:0]  req_ext;
  logic [31:0] addr_ext;
  logic [1:0]  win;
  logic        win_vld;

  assign req_ext  = 4'(req);
  assign addr_ext = 32'(req_addr);

`ifdef SBOX_ARB_FIXED_PRIO_EN
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_vld && req_ext[2'(k)]) begin
        win_vld = 1'b1;
        win     = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] scan;

  // Scan from ptr upward, wrapping modulo NREQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    scan    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + 3'(k);
      if (scan >= 3'(NREQ)) scan = scan - 3'(NREQ);
      if (!win_vld && req_ext[scan[1:0]]) begin
        win_vld = 1'b1;
        win     = scan[1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) begin
      if (({1'b0, win} + 3'd1) >= 3'(NREQ)) ptr_d = '0;
      else                                  ptr_d = win + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    rom_addr_d = rom_addr_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d    = ACCESS;
          owner_d    = win;
          rom_addr_d = addr_ext[{win, 3'b000} +: 8];
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b0;
          cnt_d      = CNT_INIT;
          gnt_d      = NREQ'(4'b0001 << win);
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = DONE;
          rdata_d  = rom_data;
          rvalid_d = NREQ'(4'b0001 << owner_q);
          ce_n_d   = 1'b1;
          oe_n_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // DONE always returns to IDLE, leaving the ROM deselected for a turnaround cycle.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rom_addr_q <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rom_addr_q <= rom_addr_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign rom_addr = rom_addr_q;
  assign rom_ce_n = ce_n_q;
  assign rom_oe_n = oe_n_q;

endmodule
